decode_stage: RTL



---
 rtl/core_pkg.sv | 58 +++++
 rtl/inst_decoder.sv | 79 +++++++
 rtl/decode_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared decode-stage types: op_t, opcode encodings, instruction field positions
// and the registered execute bundle.
package core_pkg;

  localparam int unsigned CORE_XLEN = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_ADDI = 4'd8,
    OP_LW   = 4'd9,
    OP_SW   = 4'd10,
    OP_BEQ  = 4'd11,
    OP_JAL  = 4'd12,
    OP_NOP  = 4'd13,
    OP_ILL  = 4'd14
  } op_t;

  localparam logic [5:0] OPC_ALU_R = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h01;
  localparam logic [5:0] OPC_LW    = 6'h02;
  localparam logic [5:0] OPC_SW    = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_JAL   = 6'h05;
  localparam logic [5:0] OPC_NOP   = 6'h3F;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 26;
  localparam int unsigned RD_HI    = 25;
  localparam int unsigned RD_LO    = 22;
  localparam int unsigned RS1_HI   = 21;
  localparam int unsigned RS1_LO   = 18;
  localparam int unsigned RS2_HI   = 17;
  localparam int unsigned RS2_LO   = 14;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned FUNCT_HI = 3;
  localparam int unsigned FUNCT_LO = 0;

  typedef struct packed {
    logic                 valid;
    logic [15:0]          pc;
    op_t                  op;
    logic [3:0]           rd;
    logic                 rd_we;
    logic [CORE_XLEN-1:0] rs1_data;
    logic [CORE_XLEN-1:0] rs2_data;
    logic [CORE_XLEN-1:0] imm;
    logic                 illegal;
  } dec_bundle_t;

endpackage

// File: rtl/inst_decoder.sv
// Purely combinational instruction decoder: word -> op, register fields,
// sign-extended immediate, write-enable, source usage and illegal flag.
module inst_decoder
  import core_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic [31:0]     word,
  output op_t             op,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  logic [5:0] opcode;
  logic [3:0] funct;
  logic       writes;

  assign opcode = word[OPC_HI:OPC_LO];
  assign funct  = word[FUNCT_HI:FUNCT_LO];
  assign rd     = word[RD_HI:RD_LO];
  assign rs1    = word[RS1_HI:RS1_LO];
  assign rs2    = word[RS2_HI:RS2_LO];
  assign imm    = XLEN'($signed(word[IMM_HI:IMM_LO]));

  always_comb begin
    op       = OP_ILL;
    writes   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_ALU_R: begin
        if (funct[3]) begin
          illegal = 1'b1;
        end else begin
          op       = op_t'({1'b0, funct[2:0]});
          writes   = 1'b1;
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
        end
      end
      OPC_ADDI: begin
        op       = OP_ADDI;
        writes   = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_LW: begin
        op       = OP_LW;
        writes   = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_SW: begin
        op       = OP_SW;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BEQ: begin
        op       = OP_BEQ;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        op     = OP_JAL;
        writes = 1'b1;
      end
      OPC_NOP: op = OP_NOP;
      default: illegal = 1'b1;
    endcase
  end

  assign rd_we = writes && (rd != 4'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: hold buffer, wrong-path squash, load-use interlock and
// the registered execute bundle. Define DECODE_LOAD_USE_INTERLOCK_EN for the interlock.
module decode_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = CORE_XLEN,
  parameter int unsigned NREGS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              decode_pc,
  input  logic                     decode_valid,
  input  logic [31:0]              inst_rdata,
  input  logic                     branch_taken,
  input  logic                     ex_stall,
  output logic                     decode_stall,
  output logic [$clog2(NREGS)-1:0] rf_raddr1,
  output logic [$clog2(NREGS)-1:0] rf_raddr2,
  input  logic [XLEN-1:0]          rf_rdata1,
  input  logic [XLEN-1:0]          rf_rdata2,
  output logic                     ex_valid,
  output logic [15:0]              ex_pc,
  output logic [3:0]               ex_op,
  output logic [3:0]               ex_rd,
  output logic                     ex_rd_we,
  output logic [XLEN-1:0]          ex_rs1_data,
  output logic [XLEN-1:0]          ex_rs2_data,
  output logic [XLEN-1:0]          ex_imm,
  output logic                     ex_illegal
);

  localparam int unsigned RAW = $clog2(NREGS);

  dec_bundle_t ex_q, ex_d, bundle;
  logic [31:0] hold_q, hold_d;
  logic        hold_v_q, hold_v_d;
  logic        squash_q, squash_d;

  logic [31:0]          inst_word;
  op_t                  dec_op;
  logic [3:0]           dec_rd, dec_rs1, dec_rs2;
  logic [CORE_XLEN-1:0] dec_imm;
  logic                 dec_rd_we, dec_uses_rs1, dec_uses_rs2, dec_illegal;
  logic                 lu_hazard;

  // Fetch has already moved past a stalled instruction, so decode from the held copy.
  assign inst_word = hold_v_q ? hold_q : inst_rdata;

  inst_decoder #(.XLEN(CORE_XLEN)) u_inst_decoder (
    .word     (inst_word),
    .op       (dec_op),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .imm      (dec_imm),
    .rd_we    (dec_rd_we),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  assign rf_raddr1 = RAW'(dec_rs1);
  assign rf_raddr2 = RAW'(dec_rs2);

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
  assign lu_hazard = ex_q.valid && (ex_q.op == OP_LW) && ex_q.rd_we &&
                     ((dec_uses_rs1 && (dec_rs1 == ex_q.rd)) ||
                      (dec_uses_rs2 && (dec_rs2 == ex_q.rd)));
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{dec_uses_rs1, dec_uses_rs2};
  assign lu_hazard = 1'b0;
`endif

  assign decode_stall = decode_valid && !squash_q && (ex_stall || lu_hazard) && !branch_taken;

  always_comb begin
    bundle          = '0;
    bundle.valid    = decode_valid && !squash_q;
    bundle.pc       = decode_pc;
    bundle.op       = dec_op;
    bundle.rd       = dec_rd;
    bundle.rd_we    = dec_rd_we;
    bundle.rs1_data = (dec_rs1 == 4'd0) ? '0 : CORE_XLEN'(rf_rdata1);
    bundle.rs2_data = (dec_rs2 == 4'd0) ? '0 : CORE_XLEN'(rf_rdata2);
    bundle.imm      = dec_imm;
    bundle.illegal  = dec_illegal;
  end

  always_comb begin
    ex_d     = ex_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    squash_d = branch_taken;

    if (branch_taken) begin
      ex_d.valid = 1'b0;
    end else if (ex_stall) begin
      ex_d = ex_q;
    end else if (lu_hazard) begin
      ex_d.valid = 1'b0;
    end else begin
      ex_d = bundle;
    end

    if (branch_taken || !decode_stall) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q) begin
      hold_d   = inst_rdata;
      hold_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      squash_q <= squash_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_op       = ex_q.op;
  assign ex_rd       = ex_q.rd;
  assign ex_rd_we    = ex_q.rd_we;
  assign ex_rs1_data = XLEN'(ex_q.rs1_data);
  assign ex_rs2_data = XLEN'(ex_q.rs2_data);
  assign ex_imm      = XLEN'(ex_q.imm);
  assign ex_illegal  = ex_q.illegal;

endmodule
